// File: rtl/data_mem_io.sv
// data_mem_io: data-side memory responder for the single-cycle core.
// Combinational word reads, registered word writes, a word RAM (addr[31]=0)
// and a memory-mapped I/O region (addr[31]=1) holding a console transmit
// FIFO and an optional free-running cycle counter.
//
// Build option: define DMEM_CYCLE_CNT_EN to include the CYCLE counter;
// without it 0x8000_0008 reads 0 and ignores writes.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-low reset
//   addr       in  32   byte address (word access, addr[1:0] ignored)
//   wr_data    in  32   store data
//   mem_write  in   1   store strobe, commits at next rising edge
//   rd_data    out 32   load data, combinational from addr and state
//   tx_data    out  8   FIFO head byte, 0 when empty
//   tx_valid   out  1   FIFO not empty
//   tx_ready   in   1   downstream accepts tx_data this cycle
module data_mem_io #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_write,
    output logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = 4;

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_CYCLE  = 2'd2;

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          is_io;
    logic [1:0]    sel;
    logic [AW-1:0] idx;
    logic          io_we;
    logic          ram_we;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          full;
    logic          empty;
    logic          ovf_clr;
    logic [31:0]   status;
    logic [31:0]   cycle_rd;

    // Address decode; writes are suppressed during reset
    assign is_io   = addr[31];
    assign sel     = addr[3:2];
    assign idx     = addr[AW+1:2];
    assign io_we   = mem_write && reset && is_io;
    assign ram_we  = mem_write && reset && !is_io;
    assign push    = io_we && (sel == SEL_DATA);
    assign ovf_clr = io_we && (sel == SEL_STATUS) && wr_data[2];

    // FIFO flags; a push into a full FIFO still fits if the head leaves this cycle
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign push_ok  = push && (!full || pop);
    assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];

    assign status = {24'h00_0000, count, 1'b0, overflow, empty, full};

    // RAM storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx] <= wr_data;
        end
    end

    // FIFO storage; stale entries are masked by empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo[wr_ptr] <= wr_data[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle;
    logic        cycle_we;

    assign cycle_we = io_we && (sel == SEL_CYCLE);

    // Free-running counter; a store loads it instead of incrementing
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle <= '0;
        end else if (cycle_we) begin
            cycle <= wr_data;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    assign cycle_rd = cycle;
`else
    assign cycle_rd = '0;
`endif

    // Load data mux
    always_comb begin
        rd_data = '0;
        if (!is_io) begin
            rd_data = ram[idx];
        end else begin
            case (sel)
                SEL_STATUS: rd_data = status;
                SEL_CYCLE:  rd_data = cycle_rd;
                default:    rd_data = '0;
            endcase
        end
    end

    // Address bits outside the decode are don't-care by design
    logic unused_addr;
    assign unused_addr = ^{addr[30:4], addr[1:0]};

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory responder for the single-cycle RISC-V core. It answers the core's load/store port (`alu_result` → `addr`, `wr_data`, `mem_write`, `rd_data`): combinational reads, registered word writes. It decodes a word RAM plus a small memory-mapped I/O region. The I/O region holds a console transmit FIFO with a ready/valid output stream and an optional free-running cycle counter.

## Interface

Parameters:
- `MEM_WORDS`, 64 — RAM depth in 32-bit words; power of two, ≥ 4.
- `FIFO_DEPTH`, 4 — console FIFO entries; power of two, 2..8.

Ports:
- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `reset` — in, 1 — synchronous, active-low reset.
- `addr` — in, 32 — byte address from the core's ALU result.
- `wr_data` — in, 32 — store data.
- `mem_write` — in, 1 — store strobe; the write commits at the next rising edge.
- `rd_data` — out, 32 — load data; combinational from `addr` and current state.
- `tx_data` — out, 8 — FIFO head byte; 0 when the FIFO is empty.
- `tx_valid` — out, 1 — FIFO not empty.
- `tx_ready` — in, 1 — downstream accepts `tx_data` this cycle.

## Operation

- Word-only access. `addr[1:0]` is ignored.
- **RAM region: `addr[31]`=0.**
  - Index = `addr[log2(MEM_WORDS)+1:2]`. Upper bits alias.
  - RAM contents are not reset. Reads of unwritten words are undefined.
- **I/O region: `addr[31]`=1.** Decode uses `addr[3:2]` only; `addr[30:4]` are ignored.
  - `0x8000_0000` CONSOLE_DATA.
    - Write pushes `wr_data[7:0]`.
    - Read returns 0.
  - `0x8000_0004` CONSOLE_STATUS.
    - Read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] count. All other bits 0.
    - Write with `wr_data[2]`=1 clears overflow. All other bits are ignored.
  - `0x8000_0008` CYCLE.
    - Read returns the counter.
    - Write loads `wr_data`.
  - `0x8000_000C` reads 0; writes are ignored.
- **FIFO.**
  - Pop when `tx_valid && tx_ready`.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle; count is then unchanged.
  - A push that is rejected drops the data and sets overflow.
  - A simultaneous push and pop on an empty FIFO is impossible, since `tx_valid`=0. The push is accepted.
- **CYCLE counter.**
  - +1 every cycle; wraps `0xFFFF_FFFF` → 0.
  - A write takes priority: the counter loads `wr_data` and does not increment that cycle.

## Timing

- Reads: 0-cycle combinational path from `addr` to `rd_data`, as the single-cycle datapath requires.
  - A read in the same cycle as a write to the same location returns the old value.
  - The new value is visible in the next cycle.
- Writes, FIFO push/pop, overflow set/clear, and counter update all occur on the same rising edge.
- `tx_valid`/`tx_data` are registered-state outputs. A pushed byte appears on `tx_valid` the cycle after the write.
- `tx_data` must hold stable while `tx_valid`=1 and `tx_ready`=0.
- Reset (`reset`=0 at an edge), including mid-stream:
  - FIFO emptied and pointers zeroed.
  - overflow = 0, CYCLE = 0.
  - `tx_valid`=0, `tx_data`=0.
  - STATUS reads `0x0000_0002`.
  - RAM is untouched.
  - A `mem_write` in the reset cycle is ignored.
- Count width is 4 bits, enough to cover `FIFO_DEPTH`=8.

## Configuration

- `DMEM_CYCLE_CNT_EN` defined:
  - CYCLE counter is present as described.
- `DMEM_CYCLE_CNT_EN` undefined:
  - No counter logic.
  - `0x8000_0008` reads 0; writes are ignored.
  - All other behaviour is unchanged.

## Test plan

- **RAM write/read:** write `0xDEAD_BEEF` to `0x0000_0010`, then read `0x0000_0010` and `0x0000_0013` → both return `0xDEAD_BEEF`. With `MEM_WORDS`=64, a read of `0x0000_0110` aliases to the same word. A same-cycle read during the write returns the old value.
- **FIFO fill/overflow:** `tx_ready`=0, write `0x41`..`0x45` to CONSOLE_DATA → STATUS = `0x0000_0045` (count 4, overflow, full). Write STATUS with `0x4` → `0x0000_0041`.
- **Drain:** raise `tx_ready` → bytes `0x41`,`0x42`,`0x43`,`0x44` on consecutive cycles, then `tx_valid`=0, `tx_data`=0, STATUS = `0x0000_0002`.
- **Full plus simultaneous push/pop:** FIFO full, `tx_ready`=1, write `0x5A` → push accepted, count stays 4, no overflow. `0x5A` exits after the three older bytes.
- **Counter:** load CYCLE with `0xFFFF_FFFE` → reads `0xFFFF_FFFF`, then 0, on the following cycles. Without `DMEM_CYCLE_CNT_EN`, it always reads 0.
- **Reset mid-stream:** three bytes queued, assert `reset` for one cycle → `tx_valid`=0, STATUS = `0x0000_0002`, CYCLE = 0, previously written RAM word intact.
